aes_round_sequencer: RTL and testbench

//  Iterative AES-encrypt controller: owns the 128-bit state register, round counter and FSM.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_round_counter.sv | 37 +++
 rtl/aes_round_sequencer.sv | 115 +++++++++++
 tb/tb_aes_round_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES controller definitions: block width, sequencer state encoding and
// the round-count rule tying NR to the key length NK.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  // AES round count for a key of nk 32-bit words (10/12/14 for 4/6/8).
  function automatic int unsigned NR_OF_NK(input int unsigned nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round counter for the AES sequencer.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        set count to 1 (first round after the initial key add)
//   inc         advance by one; saturates at NR
//   clr         return to 0 (highest priority)
//   cnt         current round index, also used as the round-key index
//   term_c      cnt == NR (combinational decode of cnt)
module aes_round_counter #(
  parameter int unsigned NR = 10,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic          clr,
  output logic [RW-1:0] cnt,
  output logic          term_c
);

  assign term_c = (cnt == RW'(NR));

  // Count register; never advances past NR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RW'(1);
    end else if (inc && !term_c) begin
      cnt <= cnt + RW'(1);
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-encrypt controller: holds the 128-bit cipher state, sequences
// the round-key index, drives the external round/last-round datapath and wraps
// it with valid/ready handshakes. One block in flight at a time.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     plaintext handshake; in_block sampled only at accept
//   in_block              plaintext, byte 0 in [127:120]
//   rk_idx / rk           round-key index out, round key back in same cycle
//   dp_state / dp_last    state and last-round select to the datapath
//   dp_result             combinational datapath result
//   out_valid/out_ready   ciphertext handshake; out_block held until accepted
//   busy                  high from accept until output handshake
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = 10,
  parameter int unsigned RW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_block,
  output logic [RW-1:0]        rk_idx,
  input  logic [AES_BLK_W-1:0] rk,
  output logic [AES_BLK_W-1:0] dp_state,
  output logic                 dp_last,
  input  logic [AES_BLK_W-1:0] dp_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_block,
  output logic                 busy
);

  // Reject inconsistent key-length / round-count / index-width combinations.
  if (NR != NR_OF_NK(NK) || NR >= (1 << RW)) begin : g_bad_cfg
    $error("aes_round_sequencer: NR must equal NK+6 and fit in RW bits");
  end

  seq_state_e           state_q, state_d;
  logic [AES_BLK_W-1:0] blk_q, blk_d;
  logic [RW-1:0]        cnt;
  logic                 cnt_term_c;
  logic                 cnt_load, cnt_inc, cnt_clr;

  aes_round_counter #(
    .NR (NR),
    .RW (RW)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .cnt    (cnt),
    .term_c (cnt_term_c)
  );

  // State and cipher-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
  end

  // Next-state, cipher-state update and counter control.
  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // rk_idx is 0 here, so rk is the whitening key.
        if (in_valid) begin
          blk_d    = in_block ^ rk;
          cnt_load = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        blk_d = dp_result;
        if (cnt_term_c) begin
          // Counter returns to 0 so rk_idx reads 0 outside RUN.
          cnt_clr = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decodes of registered state only; no input-to-output paths.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign dp_last   = (state_q == S_RUN) && cnt_term_c;
  assign rk_idx    = cnt;
  assign dp_state  = blk_q;
  assign out_block = blk_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (AES-128 and AES-256) with a
// behavioural round datapath and key store, checked against FIPS-197 vectors
// and a full-block AES reference model on random keys/plaintexts.
module tb_aes_round_sequencer;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] in_block  [2];
  logic [3:0]   rk_idx    [2];
  logic [127:0] rk        [2];
  logic [127:0] dp_state  [2];
  logic         dp_last   [2];
  logic [127:0] dp_result [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] out_block [2];
  logic         busy      [2];

  logic [0:14][127:0] ks [2];
  logic [7:0]         sbox [256];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_round_sequencer #(.NK(4), .NR(10), .RW(4)) u_dut128 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_block(in_block[0]),
    .rk_idx(rk_idx[0]), .rk(rk[0]), .dp_state(dp_state[0]), .dp_last(dp_last[0]),
    .dp_result(dp_result[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_block(out_block[0]), .busy(busy[0])
  );

  aes_round_sequencer #(.NK(8), .NR(14), .RW(4)) u_dut256 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_block(in_block[1]),
    .rk_idx(rk_idx[1]), .rk(rk[1]), .dp_state(dp_state[1]), .dp_last(dp_last[1]),
    .dp_result(dp_result[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_block(out_block[1]), .busy(busy[1])
  );

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [15:0] bb;
    bb = {b, b};
    return bb[15-k -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] calc_sbox(input int x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int n);
    return s[127-8*n -: 8];
  endfunction

  // One AES round on a column-major state (byte n = row + 4*col).
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t, m;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = sbox[gb(s, r + 4*((c + r) % 4))];
    m = t;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
        m[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        m[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        m[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        m[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    return m ^ k;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic int nr_of(input int u);
    return (u == 0) ? 10 : 14;
  endfunction

  // Reference: whole-block encryption from the loaded key schedule.
  function automatic logic [127:0] ref_enc(input int u, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ ks[u][0];
    for (int r = 1; r <= nr_of(u); r++) s = aes_round(s, ks[u][r], r == nr_of(u));
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Environment: key store and round datapath, both combinational.
  for (genvar g = 0; g < 2; g++) begin : g_env
    assign rk[g]        = ks[g][rk_idx[g]];
    assign dp_result[g] = aes_round(dp_state[g], rk[g], dp_last[g]);
  end

  // ---------------- bench tasks ----------------
  task automatic load_key(input int u, input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nw;
    nk = (u == 0) ? 4 : 8;
    nw = 4 * (nr_of(u) + 1);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr_of(u); r++) ks[u][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one block, trace the round index through RUN, stop in DONE.
  task automatic encrypt(input int u, input logic [127:0] pt, input logic [127:0] exp,
                         input string tag);
    int nr;
    nr = nr_of(u);
    in_valid[u] = 1'b1;
    in_block[u] = pt;
    chk({tag, ".idle_ready"}, 128'(in_ready[u]), 128'(1));
    chk({tag, ".idx0"}, 128'(rk_idx[u]), 128'(0));
    tick();
    chk({tag, ".whiten"}, dp_state[u], pt ^ ks[u][0]);
    for (int i = 1; i <= nr; i++) begin
      chk({tag, ".idx"}, 128'(rk_idx[u]), 128'(i));
      chk({tag, ".last"}, 128'(dp_last[u]), 128'(i == nr));
      chk({tag, ".run_ready"}, 128'(in_ready[u]), 128'(0));
      chk({tag, ".run_busy"}, 128'(busy[u]), 128'(1));
      chk({tag, ".run_ovld"}, 128'(out_valid[u]), 128'(0));
      // Traffic that RUN must ignore.
      in_valid[u]  = 1'($urandom);
      in_block[u]  = rnd128();
      out_ready[u] = 1'($urandom);
      tick();
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
    chk({tag, ".ovld"}, 128'(out_valid[u]), 128'(1));
    chk({tag, ".ct"}, out_block[u], exp);
    chk({tag, ".done_idx"}, 128'(rk_idx[u]), 128'(0));
  endtask

  task automatic drain(input int u, input string tag);
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    chk({tag, ".drain_ovld"}, 128'(out_valid[u]), 128'(0));
    chk({tag, ".drain_ready"}, 128'(in_ready[u]), 128'(1));
    chk({tag, ".drain_busy"}, 128'(busy[u]), 128'(0));
  endtask

  task automatic wait_out(input int u, output int cycles);
    cycles = 0;
    while (!out_valid[u] && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    logic [127:0] pt2, exp2;
    logic [255:0] key;
    int u, d;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_block[i] = '0; out_ready[i] = 1'b0;
    end
    for (int x = 0; x < 256; x++) sbox[x] = calc_sbox(x);
    load_key(0, K128);
    load_key(1, K256);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      chk("rst.ready", 128'(in_ready[i]), 128'(1));
      chk("rst.ovld", 128'(out_valid[i]), 128'(0));
      chk("rst.busy", 128'(busy[i]), 128'(0));
      chk("rst.last", 128'(dp_last[i]), 128'(0));
      chk("rst.idx", 128'(rk_idx[i]), 128'(0));
      chk("rst.state", dp_state[i], 128'(0));
    end
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1, output accepted immediately.
    encrypt(0, PT, CT1, "c1");
    drain(0, "c1");

    // FIPS-197 C.3 with five cycles of backpressure in DONE.
    encrypt(1, PT, CT3, "c3");
    for (int k = 0; k < 5; k++) begin
      in_valid[1] = 1'(k % 2 == 0);
      in_block[1] = rnd128();
      tick();
      chk("bp.ovld", 128'(out_valid[1]), 128'(1));
      chk("bp.ct", out_block[1], CT3);
      chk("bp.ready", 128'(in_ready[1]), 128'(0));
      chk("bp.busy", 128'(busy[1]), 128'(1));
    end
    in_valid[1] = 1'b0;
    drain(1, "c3");

    // Back-to-back with in_valid and out_ready held high.
    pt2  = rnd128();
    exp2 = ref_enc(0, pt2);
    in_valid[0]  = 1'b1;
    in_block[0]  = PT;
    out_ready[0] = 1'b1;
    chk("b2b.ready", 128'(in_ready[0]), 128'(1));
    tick();
    wait_out(0, cyc);
    chk("b2b.lat1", 128'(cyc), 128'(10));
    chk("b2b.ct1", out_block[0], CT1);
    in_block[0] = pt2;
    tick();
    chk("b2b.gap_ovld", 128'(out_valid[0]), 128'(0));
    chk("b2b.gap_ready", 128'(in_ready[0]), 128'(1));
    tick();
    chk("b2b.acc2_ready", 128'(in_ready[0]), 128'(0));
    chk("b2b.acc2_busy", 128'(busy[0]), 128'(1));
    wait_out(0, cyc);
    chk("b2b.lat2", 128'(cyc), 128'(10));
    chk("b2b.ct2", out_block[0], exp2);
    in_valid[0] = 1'b0;
    tick();
    out_ready[0] = 1'b0;
    chk("b2b.end_ready", 128'(in_ready[0]), 128'(1));

    // Random keys and plaintexts against the reference model.
    for (int n = 0; n < 6; n++) begin
      u   = n % 2;
      key = {rnd128(), rnd128()};
      load_key(u, key);
      pt2  = rnd128();
      exp2 = ref_enc(u, pt2);
      encrypt(u, pt2, exp2, "rnd");
      d = int'($urandom_range(0, 3));
      for (int k = 0; k < d; k++) begin
        tick();
        chk("rnd.hold", out_block[u], exp2);
      end
      drain(u, "rnd");
    end

    // Reset while in round 5, then a clean C.1 block.
    load_key(0, K128);
    in_valid[0] = 1'b1;
    in_block[0] = PT;
    tick();
    in_valid[0] = 1'b0;
    repeat (4) tick();
    chk("mid.idx5", 128'(rk_idx[0]), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("mid.ovld", 128'(out_valid[0]), 128'(0));
    chk("mid.ready", 128'(in_ready[0]), 128'(1));
    chk("mid.busy", 128'(busy[0]), 128'(0));
    chk("mid.idx", 128'(rk_idx[0]), 128'(0));
    chk("mid.state", dp_state[0], 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    encrypt(0, PT, CT1, "post_rst");
    drain(0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
